// File: rtl/reduce_exec_pkg.sv
// Shared types for the packet reduction engine: op codes, FSM states and
// the identity value each op starts its accumulation from.
package reduce_exec_pkg;

  typedef enum logic [1:0] {
    OP_XOR = 2'b00,
    OP_ADD = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_PUSH = 2'd2
  } state_e;

  // The identity is either all-zeros or all-ones, so return the fill bit
  // and let the caller replicate it to the datapath width.
  function automatic logic op_identity(input op_e op);
    return (op == OP_AND);
  endfunction

endpackage

// File: rtl/reduce_alu.sv
// One accumulate step: y = a <op> b, with ADD wrapping at the word width.
module reduce_alu
  import reduce_exec_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [1:0]        op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] y
);

  always_comb begin
    y = a ^ b;
    case (op_e'(op))
      OP_XOR:  y = a ^ b;
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = a ^ b;
    endcase
  end

endmodule

// File: rtl/reduce_exec.sv
// Packet reducer: reads a header (length + op) and N data words from a
// FWFT input FIFO and pushes one reduced word per packet to an output FIFO.
module reduce_exec
  import reduce_exec_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CNTW   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ififo_rdy,
  input  logic [DWIDTH-1:0] idata,
  output logic              ififo_pop,
  input  logic              ofifo_not_full,
  output logic              ofifo_push,
  output logic [DWIDTH-1:0] odata,
  output logic              exec_idle,
  output logic [15:0]       pkt_cnt
);

  // Handshakes: a word moves when pop (resp. push) is high at a rising edge;
  // pop implies ififo_rdy, push implies ofifo_not_full, both gated by rst_n.

  state_e            state, state_next;
  op_e               op_q, op_next;
  logic [CNTW-1:0]   cnt_q, cnt_next;
  logic [DWIDTH-1:0] acc_q, acc_next, alu_y;
  logic              hdr_take, data_take;
  logic [CNTW-1:0]   hdr_n;
  op_e               hdr_op;

  assign hdr_n  = idata[CNTW-1:0];
  assign hdr_op = op_e'(idata[CNTW+1:CNTW]);

  if (DWIDTH > CNTW + 2) begin : g_hdr_pad
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^idata[DWIDTH-1:CNTW+2];
  end

  reduce_alu #(.DWIDTH(DWIDTH)) u_alu (
    .op (op_q),
    .a  (acc_q),
    .b  (idata),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_XOR;
      cnt_q     <= '0;
      acc_q     <= '0;
      odata     <= '0;
      pkt_cnt   <= '0;
      exec_idle <= 1'b1;
    end else begin
      state     <= state_next;
      op_q      <= op_next;
      cnt_q     <= cnt_next;
      acc_q     <= acc_next;
      exec_idle <= (state_next == S_IDLE);
      // Capture the result as the FSM enters (or stays in) S_PUSH.
      if (state_next == S_PUSH) odata <= acc_next;
      if (ofifo_push) pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

  always_comb begin
    state_next = state;
    op_next    = op_q;
    cnt_next   = cnt_q;
    acc_next   = acc_q;
    if (hdr_take) begin
      op_next    = hdr_op;
      cnt_next   = hdr_n;
      acc_next   = {DWIDTH{op_identity(hdr_op)}};
      state_next = (hdr_n == '0) ? S_PUSH : S_ACC;
    end else if (data_take) begin
      acc_next = alu_y;
      cnt_next = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) state_next = S_PUSH;
    end else if (ofifo_push) begin
      state_next = S_IDLE;
    end
  end

  always_comb begin
    ififo_pop  = 1'b0;
    ofifo_push = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE: ififo_pop = ififo_rdy;
        S_ACC:  ififo_pop = ififo_rdy;
        S_PUSH: begin
          ofifo_push = ofifo_not_full;
          ififo_pop  = ififo_rdy && ofifo_not_full;
        end
        default: ;
      endcase
    end
  end

  assign hdr_take  = ififo_pop && (state != S_ACC);
  assign data_take = ififo_pop && (state == S_ACC);

endmodule

// File: doc/reduce_exec.md
REDUCE_EXEC -- requirements
Module: reduce_exec

Interface
REQ-001 Parameter DWIDTH, default 8, data word width; SHALL be at least CNTW+2.
REQ-002 Parameter CNTW, default 6, width of the length field in a header word.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port ififo_rdy  input  1  input FIFO non-empty; idata is valid (first-word-fall-through head).
REQ-006 Port idata  input  DWIDTH  input FIFO head word.
REQ-007 Port ififo_pop  output  1  consume idata this cycle; SHALL only be high when ififo_rdy is high.
REQ-008 Port ofifo_not_full  input  1  output FIFO can accept a word this cycle.
REQ-009 Port ofifo_push  output  1  write odata to the output FIFO this cycle.
REQ-010 Port odata  output  DWIDTH  packet result.
REQ-011 Port exec_idle  output  1  high when the FSM is in S_IDLE.
REQ-012 Port pkt_cnt  output  16  count of results pushed since reset, wrapping.

Function
REQ-013 Packet format: the header word is idata[CNTW-1:0] = N (0..2^CNTW-1) and idata[CNTW+1:CNTW] = op; upper bits are ignored; the header is followed by N data words.
REQ-014 op encoding: 00 XOR, 01 ADD modulo 2^DWIDTH (carry discarded), 10 AND, 11 OR.
REQ-015 The accumulator SHALL load the op identity at header accept: 0 for XOR, ADD and OR; all-ones for AND.
REQ-016 FSM states: S_IDLE, S_ACC, S_PUSH.
REQ-017 S_IDLE: if ififo_rdy, pop the header and latch N and op; go to S_ACC if N>0, else to S_PUSH.
REQ-018 S_ACC: if ififo_rdy, pop, set acc = acc op idata and decrement the remaining count; on the last word go to S_PUSH; if not ififo_rdy, hold all state.
REQ-019 S_PUSH: ofifo_push = ofifo_not_full, and odata = acc.
REQ-020 S_PUSH with ofifo_not_full low: stay in S_PUSH with odata stable.
REQ-021 S_PUSH with ofifo_not_full high and ififo_rdy high: push and pop the next header in the same cycle, then go to S_ACC, or to S_PUSH if the new N is 0.
REQ-022 S_PUSH with ofifo_not_full high and ififo_rdy low: push, then go to S_IDLE.
REQ-023 ififo_pop and ofifo_push SHALL be combinational from state and the handshake inputs; all other outputs SHALL be registered.
REQ-024 Latency: header pop at cycle 0; with no stalls, data pops at cycles 1..N and the push at cycle N+1. For N=0, the push is at cycle 1.
REQ-025 Sustained throughput: one input word per cycle across back-to-back packets, with no bubble between a push and the next header.
REQ-026 pkt_cnt SHALL increment by 1 on each ofifo_push and wrap from 0xFFFF to 0.
REQ-027 odata SHALL hold its value outside S_PUSH until the next header accept.

Reset
REQ-028 While rst_n is low at a clock edge, the block SHALL reset to: state S_IDLE, acc 0, count 0, op 00, pkt_cnt 0, odata 0, ififo_pop 0, ofifo_push 0, exec_idle 1.
REQ-029 Reset mid-packet SHALL discard the partial result with no push.
REQ-030 No ififo_pop or ofifo_push SHALL occur in any cycle in which rst_n is low.

Structure
REQ-031 Package reduce_exec_pkg SHALL hold the op enum (OP_XOR, OP_ADD, OP_AND, OP_OR), the state enum, and a function returning the op identity.
REQ-032 Combinational sub-module reduce_alu (inputs op, a, b; output y; width DWIDTH) SHALL perform the accumulate step.
REQ-033 Total RTL is expected to be roughly 150-250 lines.

Verification
REQ-034 XOR: words 0x04, 0x16, 0x05, 0x08, 0xFF with ififo_rdy held high -> one push of odata 0xE4 at cycle 5, pkt_cnt 1.
REQ-035 ADD and AND back-to-back: words 0x43, 0x80, 0x90, 0x01, 0x80 -> pushes of 0x11 then 0xFF (AND with N=0) on consecutive push opportunities with no idle cycle.
REQ-036 Backpressure: OR packet 0xC2, 0x01, 0x40 with ofifo_not_full low for 5 cycles at S_PUSH -> odata holds 0x41, no push, no pop; exactly one push when ofifo_not_full rises.
REQ-037 Starvation: ififo_rdy low for 3 cycles mid-packet -> no pop, acc unchanged, and the final result matches the unstalled run.
REQ-038 Reset: assert rst_n low after 2 of 4 data words -> no push, exec_idle 1, pkt_cnt 0; the next packet gives the correct result.
REQ-039 Wrap: 65536 zero-length packets (0x00) -> pkt_cnt returns to 0 and every odata equals 0x00.
